mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single unified memory port.
// Data wins ties unless the fetch side has been passed over STARVE_LIMIT times in a row.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        write_q, write_d;
  logic        d_req;
  logic        fetch_starved;

  assign d_req         = d_read_en | d_write_en;
  assign fetch_starved = if_req && (starve_q == LIMIT);

  // NOTE: every output and next-state signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;

    case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          write_d  = d_write_en;
          wdata_d  = d_write_en ? d_wdata : '0;
          // Count only data grants that actually made a fetch wait.
          if (!if_req)                starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end else if (if_req) begin
          state_d  = BUSY_I;
          addr_d   = if_addr;
          write_d  = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
        end
      end
      BUSY_I: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd    = 1'b1;
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = RESP_I;
        end
      end
      BUSY_D: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd    = !write_q;
        mem_wr    = write_q;
        if (mem_ack) begin
          rdata_d = write_q ? '0 : mem_rdata;
          state_d = RESP_D;
        end
      end
      RESP_I: begin
        if_ready = 1'b1;
        if_rdata = rdata_q;
        rdata_d  = '0;
        state_d  = IDLE;
      end
      RESP_D: begin
        d_ready = 1'b1;
        d_rdata = rdata_q;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of grant order, latency and data.
module tb_mem_arbiter;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_read_en, d_write_en, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_rd, mem_wr, busy;

  int total = 0;
  int bad   = 0;
  int starve_m = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    if_req = 1'b0; d_read_en = 1'b0; d_write_en = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    starve_m = 0;
  endtask

  // One granted access: requests are already driven and the arbiter is idle.
  // w = ack-wait cycles; noise scrambles the granted port's inputs and spurious acks.
  task automatic do_access(input bit fetch, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int w, input bit noise, input bit keep);
    logic [36:0]  act_b, exp_b;
    logic [132:0] act_r, exp_r;
    logic [31:0]  ret;
    if (fetch) starve_m = 0;
    else if (if_req) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
    else starve_m = 0;
    ret = (fetch || !wr) ? word : 32'h0;

    for (int k = 0; k <= w; k++) begin
      tick();
      mem_ack   = (k == w);
      mem_rdata = (k == w) ? word : $urandom;
      if (noise) begin
        if (fetch) if_addr = $urandom;
        else begin d_addr = $urandom; d_wdata = $urandom; end
      end
      sample();
      exp_b = {1'b1, !wr, wr, 2'b00, addr};
      act_b = {busy, mem_rd, mem_wr, if_ready, d_ready, mem_addr};
      total++;
      if (act_b !== exp_b) begin
        bad++;
        $display("FAIL busy_phase k=%0d fetch=%0d: got %h expected %h", k, fetch, act_b, exp_b);
      end
      if (wr) begin
        total++;
        if (mem_wdata !== wdata) begin
          bad++;
          $display("FAIL mem_wdata: got %h expected %h", mem_wdata, wdata);
        end
      end
    end

    tick();
    mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = $urandom;
    if (!keep) begin
      if (fetch) if_req = 1'b0;
      else begin d_read_en = 1'b0; d_write_en = 1'b0; end
    end
    sample();
    exp_r = {1'b1, 1'b0, 1'b0, fetch, !fetch, 32'h0, 32'h0,
             fetch ? ret : 32'h0, fetch ? 32'h0 : ret};
    act_r = {busy, mem_rd, mem_wr, if_ready, d_ready, mem_addr, mem_wdata, if_rdata, d_rdata};
    total++;
    if (act_r !== exp_r) begin
      bad++;
      $display("FAIL resp_phase fetch=%0d: got %h expected %h", fetch, act_r, exp_r);
    end

    tick();
    mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = $urandom;
    sample();
    act_r = {busy, mem_rd, mem_wr, if_ready, d_ready, mem_addr, mem_wdata, if_rdata, d_rdata};
    total++;
    if (act_r !== '0) begin
      bad++;
      $display("FAIL idle_after_resp: got %h expected 0", act_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1; d_read_en = 1'b1; d_write_en = 1'b0; mem_ack = 1'b1;
    if_addr = 32'h1234; d_addr = 32'h5678; d_wdata = '0; mem_rdata = 32'hFFFF_FFFF;
    tick();
    sample();
    total++;
    if ({busy, mem_rd, mem_wr, if_ready, d_ready, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b addr=%h expected all 0",
               busy, mem_rd, mem_wr, mem_addr);
    end
    apply_reset();
    sample();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h8C01_0004, 1, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h300;
    d_read_en = 1'b1; d_addr = 32'h2000;
    do_access(1'b0, 1'b0, 32'h2000, 32'h0, 32'hA5A5_0001, 0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h5A5A_0002, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    d_read_en = 1'b1; d_write_en = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    do_access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, $urandom, 1, 1'b0, 1'b0);
  endtask

  task automatic test_input_change();
    if_req = 1'b1; if_addr = 32'h0000_0F00;
    do_access(1'b1, 1'b0, 32'h0000_0F00, 32'h0, 32'h1357_9BDF, 3, 1'b1, 1'b0);
    d_read_en = 1'b1; d_write_en = 1'b1; d_addr = 32'h0000_0A00; d_wdata = 32'hCAFE_F00D;
    do_access(1'b0, 1'b1, 32'h0000_0A00, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 1'b0);
  endtask

  // Both requesters stay asserted; expected order follows the starvation rule.
  task automatic test_starvation();
    bit d_wins;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_read_en = 1'b1; d_addr = 32'h0000_2000;
    for (int n = 0; n < 6; n++) begin
      d_wins = (starve_m != LIMIT);
      if (d_wins) do_access(1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'hD000_0000 + n, n % 2, 1'b0, 1'b1);
      else        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'hF000_0000 + n, n % 3, 1'b0, 1'b1);
    end
    if_req = 1'b0; d_read_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_read_en = 1'b1; d_addr = 32'h80;
    tick();
    mem_ack = 1'b0;
    rst = 1'b1;
    sample();
    total++;
    if ({busy, mem_rd, mem_addr} !== {2'b11, 32'h80}) begin
      bad++;
      $display("FAIL mid_busy: got busy=%b rd=%b addr=%h expected 1 1 00000080", busy, mem_rd, mem_addr);
    end
    tick();
    rst = 1'b0; d_read_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    starve_m = 0;
    sample();
    total++;
    if ({busy, mem_rd, mem_wr, if_ready, d_ready} !== 5'b0) begin
      bad++;
      $display("FAIL after_mid_reset: got %b expected 00000", {busy, mem_rd, mem_wr, if_ready, d_ready});
    end
    tick();
    mem_ack = 1'b0;
    sample();
    total++;
    if ({busy, d_ready, d_rdata} !== '0) begin
      bad++;
      $display("FAIL late_ack_ignored: got busy=%b d_ready=%b d_rdata=%h expected 0", busy, d_ready, d_rdata);
    end
  endtask

  task automatic test_random();
    bit rq_i, rq_rd, rq_wr, noise, d_first;
    logic [31:0] ia, da, wd, wi, wdw;
    int wa, wb;
    for (int r = 0; r < 60; r++) begin
      rq_i  = 1'($urandom_range(0, 1));
      rq_rd = 1'($urandom_range(0, 1));
      rq_wr = 1'($urandom_range(0, 2) == 0);
      noise = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; wd = $urandom; wi = $urandom; wdw = $urandom;
      wa = $urandom_range(0, 3); wb = $urandom_range(0, 3);
      if_req = rq_i; if_addr = ia;
      d_read_en = rq_rd; d_write_en = rq_wr; d_addr = da; d_wdata = wd;
      d_first = (rq_rd || rq_wr) && !(rq_i && starve_m == LIMIT);
      if (d_first) begin
        do_access(1'b0, rq_wr, da, wd, wdw, wa, noise, 1'b0);
        if (rq_i) do_access(1'b1, 1'b0, ia, 32'h0, wi, wb, noise, 1'b0);
      end else if (rq_i) begin
        do_access(1'b1, 1'b0, ia, 32'h0, wi, wa, noise, 1'b0);
        if (rq_rd || rq_wr) do_access(1'b0, rq_wr, da, wd, wdw, wb, noise, 1'b0);
      end else begin
        mem_ack = noise;
        tick();
        sample();
        mem_ack = 1'b0;
        total++;
        if ({busy, mem_rd, mem_wr, if_ready, d_ready} !== 5'b0) begin
          bad++;
          $display("FAIL idle_no_req: got %b expected 00000", {busy, mem_rd, mem_wr, if_ready, d_ready});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_input_change();
    test_starvation();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
